// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator: request-position counters, a display pipeline
// delayed by LOOKAHEAD enabled cycles, sync/blank decode, strobes and a per-frame test pattern.
module vga_timing_gen #(
  parameter int unsigned  H_ACTIVE    = 640,
  parameter int unsigned  H_FP        = 16,
  parameter int unsigned  H_SYNC      = 96,
  parameter int unsigned  H_BP        = 48,
  parameter int unsigned  V_ACTIVE    = 480,
  parameter int unsigned  V_FP        = 10,
  parameter int unsigned  V_SYNC      = 2,
  parameter int unsigned  V_BP        = 33,
  parameter bit           H_SYNC_POL  = 1'b0,
  parameter bit           V_SYNC_POL  = 1'b0,
  parameter int unsigned  LOOKAHEAD   = 2,
  parameter int unsigned  FRAME_CNT_W = 8,
  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW          = $clog2(H_TOTAL),
  localparam int unsigned YW          = $clog2(V_TOTAL)
) (
  input  logic                   i_clk_pixel,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [1:0]             i_pattern,
  output logic [XW-1:0]          o_req_x,
  output logic [YW-1:0]          o_req_y,
  output logic                   o_req_valid,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_blank,
  output logic [XW-1:0]          o_x_pos,
  output logic [YW-1:0]          o_y_pos,
  output logic                   o_line_start,
  output logic                   o_frame_start,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic [2:0][7:0]        o_data_test
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam int unsigned LA_PREV  = (LOOKAHEAD > 1) ? (LOOKAHEAD - 2) : 0;

  logic [XW-1:0]          h_cnt, h_next;
  logic [YW-1:0]          v_cnt, v_next;
  logic [XW-1:0]          bar_cnt, bar_cnt_next;
  logic [2:0]             bar_idx, bar_idx_next;
  logic [1:0]             pat_q, pat_eff;
  logic                   req_valid_q;
  logic                   req_origin;

  logic                   new_blank, new_hs, new_vs, new_line0, new_frame0;
  logic [2:0][7:0]        new_rgb;
  logic [7:0]             x8, y8;
  logic                   h_act, v_act;

  logic [XW-1:0]          x_pipe      [LOOKAHEAD];
  logic [YW-1:0]          y_pipe      [LOOKAHEAD];
  logic                   blank_pipe  [LOOKAHEAD];
  logic                   hs_pipe     [LOOKAHEAD];
  logic                   vs_pipe     [LOOKAHEAD];
  logic [2:0][7:0]        rgb_pipe    [LOOKAHEAD];
  logic                   line0_pipe  [LOOKAHEAD];
  logic                   frame0_pipe [LOOKAHEAD];

  logic                   in_line0, in_frame0;
  logic                   line_start_q, frame_start_q, seen_frame;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // Next raster position and per-line bar tracker (replaces x / (H_ACTIVE/8))
  always_comb begin
    h_next       = h_cnt;
    v_next       = v_cnt;
    bar_cnt_next = bar_cnt;
    bar_idx_next = bar_idx;
    if (32'(h_cnt) == H_TOTAL - 1) begin
      h_next       = '0;
      bar_cnt_next = '0;
      bar_idx_next = '0;
      if (32'(v_cnt) == V_TOTAL - 1) begin
        v_next = '0;
      end else begin
        v_next = v_cnt + YW'(1);
      end
    end else begin
      h_next = h_cnt + XW'(1);
      if (32'(bar_cnt) == BAR_W - 1) begin
        bar_cnt_next = '0;
        if (bar_idx != 3'd7) begin
          bar_idx_next = bar_idx + 3'd1;
        end
      end else begin
        bar_cnt_next = bar_cnt + XW'(1);
      end
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      pat_q       <= '0;
      req_valid_q <= 1'b1;
    end else if (i_en) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      bar_cnt     <= bar_cnt_next;
      bar_idx     <= bar_idx_next;
      req_valid_q <= (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
      if (req_origin) begin
        pat_q <= i_pattern;
      end
    end
  end

  // Decode of the request position; the pattern latched at (0,0) already applies to that pixel
  always_comb begin
    req_origin = (h_cnt == '0) && (v_cnt == '0);
    pat_eff    = req_origin ? i_pattern : pat_q;
    h_act      = 32'(h_cnt) < H_ACTIVE;
    v_act      = 32'(v_cnt) < V_ACTIVE;
    new_blank  = ~(h_act & v_act);
    new_hs     = ((32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    new_vs     = ((32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    new_line0  = (h_cnt == '0);
    new_frame0 = req_origin;
    x8         = 8'(h_cnt);
    y8         = 8'(v_cnt);
    new_rgb    = '0;
    if (!new_blank) begin
      case (pat_eff)
        2'd1:    new_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        2'd2:    new_rgb = {x8, y8, x8 ^ y8};
        2'd3:    new_rgb = {3{{8{x8[5] ^ y8[5]}}}};
        default: new_rgb = '0;
      endcase
    end
  end

  // Flags about to enter the last stage drive the strobes on the same edge
  always_comb begin
    in_line0  = (LOOKAHEAD == 1) ? new_line0  : line0_pipe[LA_PREV];
    in_frame0 = (LOOKAHEAD == 1) ? new_frame0 : frame0_pipe[LA_PREV];
  end

  always_ff @(posedge i_clk_pixel) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LOOKAHEAD; k++) begin
        x_pipe[k]      <= '0;
        y_pipe[k]      <= '0;
        blank_pipe[k]  <= 1'b1;
        hs_pipe[k]     <= ~H_SYNC_POL;
        vs_pipe[k]     <= ~V_SYNC_POL;
        rgb_pipe[k]    <= '0;
        line0_pipe[k]  <= 1'b0;
        frame0_pipe[k] <= 1'b0;
      end
    end else if (i_en) begin
      x_pipe[0]      <= h_cnt;
      y_pipe[0]      <= v_cnt;
      blank_pipe[0]  <= new_blank;
      hs_pipe[0]     <= new_hs;
      vs_pipe[0]     <= new_vs;
      rgb_pipe[0]    <= new_rgb;
      line0_pipe[0]  <= new_line0;
      frame0_pipe[0] <= new_frame0;
      for (int k = 1; k < LOOKAHEAD; k++) begin
        x_pipe[k]      <= x_pipe[k-1];
        y_pipe[k]      <= y_pipe[k-1];
        blank_pipe[k]  <= blank_pipe[k-1];
        hs_pipe[k]     <= hs_pipe[k-1];
        vs_pipe[k]     <= vs_pipe[k-1];
        rgb_pipe[k]    <= rgb_pipe[k-1];
        line0_pipe[k]  <= line0_pipe[k-1];
        frame0_pipe[k] <= frame0_pipe[k-1];
      end
    end
  end

  // Strobes last one clock regardless of i_en; first frame after reset is not counted
  always_ff @(posedge i_clk_pixel) begin
    if (!i_rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      seen_frame    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      line_start_q  <= i_en & in_line0;
      frame_start_q <= i_en & in_frame0;
      if (i_en && in_frame0) begin
        seen_frame <= 1'b1;
        if (seen_frame) begin
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
      end
    end
  end

  assign o_req_x       = h_cnt;
  assign o_req_y       = v_cnt;
  assign o_req_valid   = req_valid_q;
  assign o_hsync       = hs_pipe[LOOKAHEAD-1];
  assign o_vsync       = vs_pipe[LOOKAHEAD-1];
  assign o_blank       = blank_pipe[LOOKAHEAD-1];
  assign o_x_pos       = x_pipe[LOOKAHEAD-1];
  assign o_y_pos       = y_pipe[LOOKAHEAD-1];
  assign o_data_test   = rgb_pipe[LOOKAHEAD-1];
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_count = frame_cnt;

endmodule
